// File: rtl/key_pkg.sv
// Shared constants for the key debouncer: default timing at 25 MHz and the key index map.
package key_pkg;

  localparam int KEY_SYNC_STAGES   = 2;
  localparam int KEY_STABLE_CYCLES = 250000;
  localparam int KEY_REPEAT_DELAY  = 12500000;
  localparam int KEY_REPEAT_PERIOD = 2500000;

  localparam int KEY_SPEED   = 0;
  localparam int KEY_UP      = 1;
  localparam int KEY_DOWN    = 2;
  localparam int KEY_LEFT    = 3;
  localparam int KEY_RIGHT   = 4;
  localparam int KEY_MISSILE = 5;

  // Width of a counter that must hold the values 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key channel: synchroniser, stability counter, press/release pulses.
// Auto-repeat press pulses are built only when KEY_REPEAT_EN is defined.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int SYNC_STAGES   = KEY_SYNC_STAGES,
  parameter int STABLE_CYCLES = KEY_STABLE_CYCLES,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int REPEAT_DELAY  = KEY_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = KEY_REPEAT_PERIOD
) (
  input  logic CLK,
  input  logic RST,
  input  logic keyin,
  output logic keyout,
  output logic keypress,
  output logic keyrelease
);

  if (SYNC_STAGES < 2 || STABLE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("key_debounce_ch: illegal parameter value");
  end

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [CW-1:0]          cnt;
  logic                   s;
  logic                   toggle;

  assign s      = sync_p0[SYNC_STAGES-1] ^ ACTIVE_LOW;
  assign toggle = (s != keyout) && (cnt == CNT_LAST);

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = cnt_width(RMAX);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt;
  logic          rfirst;
  logic          rep_hit;

  // The first repeat waits the long delay, later ones the short period.
  assign rep_hit = rfirst ? (rcnt == DELAY_LAST) : (rcnt == PERIOD_LAST);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_p0    <= '0;
      cnt        <= '0;
      keyout     <= 1'b0;
      keypress   <= 1'b0;
      keyrelease <= 1'b0;
`ifdef KEY_REPEAT_EN
      rcnt       <= '0;
      rfirst     <= 1'b1;
`endif
    end else begin
      sync_p0    <= {sync_p0[SYNC_STAGES-2:0], keyin};
      keypress   <= 1'b0;
      keyrelease <= 1'b0;
      if (s == keyout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt        <= '0;
        keyout     <= ~keyout;
        keypress   <= ~keyout;
        keyrelease <= keyout;
      end else begin
        cnt <= cnt + 1'b1;
      end
`ifdef KEY_REPEAT_EN
      // Idle, rising and falling cycles all restart the repeat timing.
      if (!keyout || toggle) begin
        rcnt   <= '0;
        rfirst <= 1'b1;
      end else if (rep_hit) begin
        rcnt     <= '0;
        rfirst   <= 1'b0;
        keypress <= 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// N-channel key debouncer top: maps the key vectors onto independent channels.
// Optional auto-repeat on keypress is enabled with the KEY_REPEAT_EN macro.
module key_debouncer
  import key_pkg::*;
#(
  parameter int N_KEYS        = 6,
  parameter int SYNC_STAGES   = KEY_SYNC_STAGES,
  parameter int STABLE_CYCLES = KEY_STABLE_CYCLES,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int REPEAT_DELAY  = KEY_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = KEY_REPEAT_PERIOD
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] keyin,
  output logic [N_KEYS-1:0] keyout,
  output logic [N_KEYS-1:0] keypress,
  output logic [N_KEYS-1:0] keyrelease
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .CLK       (CLK),
      .RST       (RST),
      .keyin     (keyin[i]),
      .keyout    (keyout[i]),
      .keypress  (keypress[i]),
      .keyrelease(keyrelease[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: directed scenarios followed by random bouncing keys and resets.
module tb_key_debouncer;
  import key_pkg::*;

  localparam int N      = 6;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int RD     = 10;
  localparam int RP     = 3;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [N-1:0] keyin = '0;
  logic [N-1:0] keyout, keypress, keyrelease;

  always #5 CLK = ~CLK;

  key_debouncer #(
    .N_KEYS(N), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLK(CLK), .RST(RST), .keyin(keyin),
    .keyout(keyout), .keypress(keypress), .keyrelease(keyrelease)
  );

  typedef struct packed {
    logic [N-1:0] ko;
    logic [N-1:0] kp;
    logic [N-1:0] kr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: the synchronised level is keyin delayed by SYNC edges; a key's output
  // flips once the last STABLE synchronised samples all disagree with it.
  logic [N-1:0] pipe [SYNC];
  logic [N-1:0] win  [STABLE];
  logic [N-1:0] m_ko = '0;
  longint       rise_at [N];
  longint       edge_n = 0;

  initial begin
    for (int k = 0; k < SYNC; k++) pipe[k] = '0;
    for (int k = 0; k < STABLE; k++) win[k] = '0;
    for (int c = 0; c < N; c++) rise_at[c] = 0;
  end

  always @(posedge CLK) begin : model
    logic [N-1:0] s, kp, kr, nko;
    logic         all_diff;
    longint       d;
    exp_t         e;
    edge_n++;
    kp = '0;
    kr = '0;
    if (RST) begin
      for (int k = 0; k < SYNC; k++) pipe[k] = '0;
      for (int k = 0; k < STABLE; k++) win[k] = '0;
      m_ko = '0;
    end else begin
      s = pipe[SYNC-1];
      for (int k = SYNC-1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = keyin;
      for (int k = STABLE-1; k > 0; k--) win[k] = win[k-1];
      win[0] = s;
      nko = m_ko;
      for (int c = 0; c < N; c++) begin
        all_diff = 1'b1;
        for (int k = 0; k < STABLE; k++)
          if (win[k][c] == m_ko[c]) all_diff = 1'b0;
        if (all_diff) begin
          nko[c] = ~m_ko[c];
          if (m_ko[c]) kr[c] = 1'b1;
          else begin
            kp[c] = 1'b1;
            rise_at[c] = edge_n;
          end
        end
`ifdef KEY_REPEAT_EN
        else if (m_ko[c]) begin
          d = edge_n - rise_at[c];
          if (d == RD || (d > RD && ((d - RD) % RP) == 0)) kp[c] = 1'b1;
        end
`endif
      end
      m_ko = nko;
    end
    e.ko = m_ko;
    e.kp = kp;
    e.kr = kr;
    exp_q.push_back(e);
  end

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at t=%0t actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("keyout", keyout, e.ko);
      check("keypress", keypress, e.kp);
      check("keyrelease", keyrelease, e.kr);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    // Keys held through reset.
    keyin = '1;
    RST   = 1'b1;
    cyc(4);
    RST = 1'b0;
    cyc(10);
    keyin = '0;
    cyc(10);
    // Bouncing press on KEY_UP.
    for (int i = 0; i < 10; i++) begin
      keyin[KEY_UP] = (i % 2 == 0);
      cyc(2);
    end
    keyin[KEY_UP] = 1'b1;
    cyc(12);
    // Release with a 3-cycle glitch.
    keyin[KEY_UP] = 1'b0;
    cyc(2);
    keyin[KEY_UP] = 1'b1;
    cyc(3);
    keyin[KEY_UP] = 1'b0;
    cyc(12);
    // Simultaneous channels.
    keyin[KEY_SPEED]   = 1'b1;
    keyin[KEY_MISSILE] = 1'b1;
    cyc(12);
    keyin[KEY_SPEED]   = 1'b0;
    keyin[KEY_MISSILE] = 1'b0;
    cyc(12);
    // Reset in the middle of a debounce.
    keyin[KEY_DOWN] = 1'b1;
    cyc(3);
    RST = 1'b1;
    cyc(2);
    RST = 1'b0;
    cyc(12);
    keyin[KEY_DOWN] = 1'b0;
    cyc(12);
    // Long hold for auto-repeat.
    keyin[KEY_LEFT] = 1'b1;
    cyc(30);
    keyin[KEY_LEFT] = 1'b0;
    cyc(12);
    // Random bouncing: low channels chatter, high channels are held for long stretches.
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        if (c < 3) begin
          if ($urandom_range(0, 3) == 0) keyin[c] = ~keyin[c];
        end else begin
          if ($urandom_range(0, 39) == 0) keyin[c] = ~keyin[c];
        end
      end
      RST = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    RST = 1'b0;
    cyc(3);
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
